// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// Holds the arbiter state encoding, the requester IDs and the default bus widths.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF    = 8;
  localparam int DATA_W_DEF    = 8;
  localparam int MAX_BURST_DEF = 4;

  // Wide enough for MAX_BURST up to 15
  localparam int BURST_W = 4;

  typedef enum logic [1:0] {
    ARB_FREE   = 2'b00,
    ARB_LOCKED = 2'b01,
    ARB_YIELD  = 2'b10
  } arb_state_e;

  typedef enum logic {
    REQ_C = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  // Burst counter increment that holds at the configured ceiling
  function automatic logic [BURST_W-1:0] burst_inc(input logic [BURST_W-1:0] cnt,
                                                   input logic [BURST_W-1:0] ceil);
    return (cnt >= ceil) ? ceil : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the CPU port, debug port and shared memory bus around mem_arbiter.
// master = requesters plus memory (the arbiter's environment), slave = the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_rvalid;
  logic              c_wait;
  logic              cpu_halt;

  logic              d_req;
  logic              d_we;
  logic              d_lock;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;

  logic [DATA_W-1:0] rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output c_req, c_we, c_addr, c_wdata, cpu_halt,
    output d_req, d_we, d_lock, d_addr, d_wdata,
    output mem_rdata,
    input  c_gnt, c_rvalid, c_wait, d_gnt, d_rvalid, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, cpu_halt,
    input  d_req, d_we, d_lock, d_addr, d_wdata,
    input  mem_rdata,
    output c_gnt, c_rvalid, c_wait, d_gnt, d_rvalid, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read memory between the CPU (C) and a
// debug/loader master (D), with locked D bursts bounded by a forced CPU yield slot.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.slave  bus
);

  localparam logic [BURST_W-1:0] MAX_CNT = BURST_W'(MAX_BURST);

  arb_state_e         state_q;
  req_id_e            last_q;
  logic [BURST_W-1:0] burst_cnt_q;
  logic               c_rvalid_q;
  logic               d_rvalid_q;

  logic               c_gnt;
  logic               d_gnt;
  logic               yield_now;
  logic               c_rvalid_d;
  logic               d_rvalid_d;

  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;

  // Grant decode; all grants are held off while reset is asserted
  always_comb begin
    c_gnt     = 1'b0;
    d_gnt     = 1'b0;
    yield_now = 1'b0;
    unique case (state_q)
      ARB_FREE: begin
        if (bus.cpu_halt) begin
          d_gnt = bus.d_req;
          c_gnt = bus.c_req & ~bus.d_req;
        end else if (bus.c_req && bus.d_req) begin
          if (last_q == REQ_C) d_gnt = 1'b1;
          else                 c_gnt = 1'b1;
        end else begin
          c_gnt = bus.c_req;
          d_gnt = bus.d_req;
        end
      end
      ARB_LOCKED: begin
        yield_now = bus.d_lock & bus.c_req & ~bus.cpu_halt & (burst_cnt_q == MAX_CNT);
        d_gnt     = bus.d_req & ~yield_now;
      end
      ARB_YIELD: begin
        c_gnt = bus.c_req;
      end
      default: begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
      end
    endcase
    if (!reset_n) begin
      c_gnt = 1'b0;
      d_gnt = 1'b0;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_we    = bus.d_we;
      mem_addr  = bus.d_addr;
      mem_wdata = bus.d_wdata;
    end else if (c_gnt) begin
      mem_we    = bus.c_we;
      mem_addr  = bus.c_addr;
      mem_wdata = bus.c_wdata;
    end
  end

  assign c_rvalid_d = c_gnt & ~bus.c_we;
  assign d_rvalid_d = d_gnt & ~bus.d_we;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARB_FREE;
      last_q      <= REQ_C;
      burst_cnt_q <= '0;
      c_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
    end else begin
      c_rvalid_q <= c_rvalid_d;
      d_rvalid_q <= d_rvalid_d;

      if (d_gnt)      last_q <= REQ_D;
      else if (c_gnt) last_q <= REQ_C;

      unique case (state_q)
        ARB_FREE: begin
          if (d_gnt && bus.d_lock) begin
            state_q     <= ARB_LOCKED;
            burst_cnt_q <= BURST_W'(1);
          end
        end
        ARB_LOCKED: begin
          if (yield_now) begin
            state_q     <= ARB_YIELD;
            burst_cnt_q <= '0;
          end else if (!bus.d_lock) begin
            state_q     <= ARB_FREE;
            burst_cnt_q <= '0;
          end else if (d_gnt) begin
            burst_cnt_q <= burst_inc(burst_cnt_q, MAX_CNT);
          end
        end
        ARB_YIELD: begin
          // A yield slot nobody uses is abandoned rather than held open
          if (c_gnt || !bus.c_req) begin
            state_q     <= bus.d_lock ? ARB_LOCKED : ARB_FREE;
            burst_cnt_q <= '0;
          end
        end
        default: begin
          state_q     <= ARB_FREE;
          burst_cnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.c_gnt     = c_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.c_wait    = bus.c_req & ~c_gnt;
  assign bus.c_rvalid  = c_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.rdata     = bus.mem_rdata;
  assign bus.mem_en    = c_gnt | d_gnt;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a small synchronous memory model behind the arbiter,
// inputs driven just after each rising edge, outputs checked at the falling edge.
module tb_mem_arbiter;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  logic [7:0]  mem [256];
  logic [11:0] lock_d_pat;
  logic [11:0] lock_c_pat;

  mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read memory: data appears the cycle after a read strobe
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  always @(negedge clk) begin
    if (bus.mem_en)
      $display("txn t=%0t port=%s we=%0b addr=%02h wdata=%02h",
               $time, bus.d_gnt ? "D" : "C", bus.mem_we, bus.mem_addr, bus.mem_wdata);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid_cyc();
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    lock_d_pat = 12'b001111001111;
    lock_c_pat = 12'b100000100000;

    reset_n       = 1'b0;
    bus.c_req     = 1'b1;
    bus.c_we      = 1'b0;
    bus.c_addr    = 8'h10;
    bus.c_wdata   = 8'h00;
    bus.cpu_halt  = 1'b0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_lock    = 1'b0;
    bus.d_addr    = 8'h40;
    bus.d_wdata   = 8'h00;
    bus.mem_rdata = 8'h00;

    // Held in reset with a request pending
    mid_cyc();
    chk("rst_c_gnt", bus.c_gnt, 1'b0);
    chk("rst_mem_en", bus.mem_en, 1'b0);
    chk("rst_c_rvalid", bus.c_rvalid, 1'b0);
    chk("rst_d_rvalid", bus.d_rvalid, 1'b0);

    // Single CPU read of 0x10
    next_cyc();
    reset_n = 1'b1;
    mid_cyc();
    chk("c_rd_gnt", bus.c_gnt, 1'b1);
    chk("c_rd_mem_en", bus.mem_en, 1'b1);
    chk("c_rd_addr", bus.mem_addr, 8'h10);
    chk("c_rd_we", bus.mem_we, 1'b0);
    next_cyc();
    bus.c_req = 1'b0;
    mid_cyc();
    chk("c_rd_rvalid", bus.c_rvalid, 1'b1);
    chk("c_rd_rdata", bus.rdata, 8'h4A);
    chk("c_rd_d_rvalid", bus.d_rvalid, 1'b0);
    chk("c_rd_idle_gnt", bus.c_gnt, 1'b0);

    // Round-robin contention, both reading (C @0x10, D @0x40)
    next_cyc();
    bus.c_req = 1'b1;
    bus.d_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mid_cyc();
      chk($sformatf("rr_d_gnt%0d", i), bus.d_gnt, (i % 2 == 0));
      chk($sformatf("rr_c_gnt%0d", i), bus.c_gnt, (i % 2 == 1));
      chk($sformatf("rr_c_wait%0d", i), bus.c_wait, (i % 2 == 0));
      chk($sformatf("rr_addr%0d", i), bus.mem_addr, (i % 2 == 0) ? 8'h40 : 8'h10);
      chk($sformatf("rr_d_rvalid%0d", i), bus.d_rvalid, (i % 2 == 1));
      chk($sformatf("rr_c_rvalid%0d", i), bus.c_rvalid, (i > 0) && (i % 2 == 0));
      if (i > 0)
        chk($sformatf("rr_rdata%0d", i), bus.rdata, (i % 2 == 1) ? 8'h1A : 8'h4A);
      next_cyc();
    end

    // One idle cycle: bus outputs return to zero
    bus.c_req = 1'b0;
    bus.d_req = 1'b0;
    mid_cyc();
    chk("idle_mem_en", bus.mem_en, 1'b0);
    chk("idle_mem_addr", bus.mem_addr, 8'h00);
    chk("idle_c_wait", bus.c_wait, 1'b0);
    next_cyc();

    // Locked D burst against a waiting CPU: 4 D, exit cycle, 1 C, repeat
    bus.c_req  = 1'b1;
    bus.d_req  = 1'b1;
    bus.d_lock = 1'b1;
    for (int i = 0; i < 12; i++) begin
      mid_cyc();
      chk($sformatf("lk_d_gnt%0d", i), bus.d_gnt, lock_d_pat[i]);
      chk($sformatf("lk_c_gnt%0d", i), bus.c_gnt, lock_c_pat[i]);
      chk($sformatf("lk_c_wait%0d", i), bus.c_wait, !lock_c_pat[i]);
      next_cyc();
    end
    bus.c_req  = 1'b0;
    bus.d_req  = 1'b0;
    bus.d_lock = 1'b0;
    mid_cyc();
    chk("lk_rel_mem_en", bus.mem_en, 1'b0);
    next_cyc();

    // Halted CPU: D writes 0xA5 to 0x20 every cycle, C is never served
    bus.cpu_halt = 1'b1;
    bus.c_req    = 1'b1;
    bus.d_req    = 1'b1;
    bus.d_we     = 1'b1;
    bus.d_addr   = 8'h20;
    bus.d_wdata  = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      mid_cyc();
      chk($sformatf("halt_d_gnt%0d", i), bus.d_gnt, 1'b1);
      chk($sformatf("halt_c_gnt%0d", i), bus.c_gnt, 1'b0);
      chk($sformatf("halt_we%0d", i), bus.mem_we, 1'b1);
      chk($sformatf("halt_wdata%0d", i), bus.mem_wdata, 8'hA5);
      chk($sformatf("halt_addr%0d", i), bus.mem_addr, 8'h20);
      next_cyc();
    end

    // D reads back 0x20; the preceding write must not raise rvalid
    bus.cpu_halt = 1'b0;
    bus.c_req    = 1'b0;
    bus.d_we     = 1'b0;
    mid_cyc();
    chk("rb_d_gnt", bus.d_gnt, 1'b1);
    chk("rb_wr_no_rvalid", bus.d_rvalid, 1'b0);
    next_cyc();
    bus.d_req = 1'b0;
    mid_cyc();
    chk("rb_d_rvalid", bus.d_rvalid, 1'b1);
    chk("rb_rdata", bus.rdata, 8'hA5);
    chk("rb_c_rvalid", bus.c_rvalid, 1'b0);
    next_cyc();

    // D locked read of 0x30, then reset before the return cycle
    bus.d_req  = 1'b1;
    bus.d_lock = 1'b1;
    bus.d_addr = 8'h30;
    mid_cyc();
    chk("rst1_d_gnt", bus.d_gnt, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst1_gnt_low", bus.d_gnt, 1'b0);
    chk("rst1_mem_en_low", bus.mem_en, 1'b0);
    next_cyc();
    mid_cyc();
    chk("rst1_d_rvalid", bus.d_rvalid, 1'b0);
    next_cyc();
    reset_n    = 1'b1;
    bus.c_req  = 1'b1;
    bus.d_lock = 1'b0;
    mid_cyc();
    chk("rst1_post_d_gnt", bus.d_gnt, 1'b1);
    chk("rst1_post_c_gnt", bus.c_gnt, 1'b0);
    chk("rst1_post_d_rvalid", bus.d_rvalid, 1'b0);
    next_cyc();

    // Enter the locked state again, reset, and confirm the lock is gone
    bus.c_req  = 1'b0;
    bus.d_lock = 1'b1;
    mid_cyc();
    chk("rst2_d_gnt", bus.d_gnt, 1'b1);
    #2;
    reset_n = 1'b0;
    next_cyc();
    bus.c_req = 1'b1;
    bus.d_req = 1'b0;
    mid_cyc();
    chk("rst2_c_gnt_in_rst", bus.c_gnt, 1'b0);
    next_cyc();
    reset_n = 1'b1;
    mid_cyc();
    chk("rst2_post_c_gnt", bus.c_gnt, 1'b1);
    chk("rst2_post_d_rvalid", bus.d_rvalid, 1'b0);
    next_cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
